// File: rtl/irq_trap_ctrl.sv
// Interrupt/trap entry controller: takes PIC requests and edge-detected NMIs at
// instruction-retire boundaries, saves return PCs and redirects fetch.
module irq_trap_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0040,
    parameter logic [31:0] VEC_STRIDE = 32'd4,
    parameter logic [31:0] NMI_VEC    = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_inter,
    input  logic        en_nmi,
    input  logic        int_req,
    input  logic [2:0]  int_num,
    input  logic        nmi,
    input  logic        instr_retire,
    input  logic [31:0] pc_next,
    input  logic        mret,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        int_ack,
    output logic [2:0]  ack_num,
    output logic        in_isr,
    output logic        in_nmi,
    output logic [31:0] epc,
    output logic [31:0] nmi_epc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISR     = 2'd1,
        S_NMI     = 2'd2,
        S_NMI_ISR = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        nmi_q;
    logic        nmi_pending;
    logic        nmi_edge;
    logic        nmi_live;
    logic        mret_ok;
    logic        nmi_take;
    logic        int_take;
    logic [31:0] target_pc;

    // An edge seen in the deciding cycle counts as pending, so a rising NMI
    // can be taken on the very retire it coincides with.
    assign nmi_edge = nmi & ~nmi_q;
    assign nmi_live = nmi_pending | nmi_edge;

    // Priority: an accepted mret blocks both takes; NMI beats maskable.
    assign mret_ok  = instr_retire & mret & (state != S_IDLE);
    assign nmi_take = instr_retire & ~mret_ok & nmi_live & en_nmi &
                      ((state == S_IDLE) || (state == S_ISR));
    assign int_take = instr_retire & ~mret_ok & ~nmi_take & int_req &
                      en_inter & (state == S_IDLE);

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    // NOTE: defaulting state_nxt first keeps every path assigned, so no latch
    // is inferred for the unlisted cases.
    always_comb begin
        state_nxt = state;
        if (mret_ok) begin
            case (state)
                S_NMI:     state_nxt = S_IDLE;
                S_NMI_ISR: state_nxt = S_ISR;
                S_ISR:     state_nxt = S_IDLE;
                default:   state_nxt = state;
            endcase
        end else if (nmi_take) begin
            state_nxt = (state == S_ISR) ? S_NMI_ISR : S_NMI;
        end else if (int_take) begin
            state_nxt = S_ISR;
        end
    end

    // Output logic: handler flags from state, redirect target for this decision
    always_comb begin
        in_isr    = (state == S_ISR) || (state == S_NMI_ISR);
        in_nmi    = (state == S_NMI) || (state == S_NMI_ISR);
        target_pc = VEC_BASE + ({29'd0, int_num} * VEC_STRIDE);
        if (mret_ok) begin
            target_pc = (state == S_ISR) ? epc : nmi_epc;
        end else if (nmi_take) begin
            target_pc = NMI_VEC;
        end
    end

    // Registered strobes, saved PCs and the NMI edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
            int_ack     <= 1'b0;
            ack_num     <= 3'd0;
            epc         <= 32'd0;
            nmi_epc     <= 32'd0;
            nmi_q       <= 1'b0;
            nmi_pending <= 1'b0;
        end else begin
            redirect    <= mret_ok | nmi_take | int_take;
            int_ack     <= int_take;
            nmi_q       <= nmi;
            nmi_pending <= nmi_take ? 1'b0 : nmi_live;
            if (mret_ok | nmi_take | int_take) begin
                redirect_pc <= target_pc;
            end
            if (int_take) begin
                ack_num <= int_num;
                epc     <= pc_next;
            end
            if (nmi_take) begin
                nmi_epc <= pc_next;
            end
        end
    end

endmodule

// File: doc/irq_trap_ctrl.md
Name: irq_trap_ctrl

Overview:
- CPU-side consumer of the PIC interrupt interface.
- Accepts the PIC's level request and 3-bit priority-encoded number, plus an edge-triggered NMI.
- Decides at instruction-retire boundaries whether to enter a handler, saves the return PC and redirects fetch to the handler vector.
- Returns PICs an acknowledge, handles mret return, and supports one level of NMI preemption over a maskable ISR.

Parameters:
- VEC_BASE, 32'h0000_0040, base address of the maskable vector table.
- VEC_STRIDE, 4, byte spacing between maskable vectors.
- NMI_VEC, 32'h0000_0020, NMI handler address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en_inter  in  1  global maskable-interrupt enable.
- en_nmi  in  1  NMI enable.
- int_req  in  1  level request from PIC.
- int_num  in  3  request number from PIC; valid while int_req=1.
- nmi  in  1  NMI line; rising edge is significant.
- instr_retire  in  1  an instruction retires this cycle; the only legal take/return point.
- pc_next  in  32  address of the instruction that would execute after the retiring one.
- mret  in  1  the retiring instruction is mret; qualified by instr_retire.
- redirect  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  32  target address, valid when redirect=1.
- int_ack  out  1  one-cycle acknowledge to the PIC.
- ack_num  out  3  number being acknowledged, valid with int_ack.
- in_isr  out  1  maskable handler active.
- in_nmi  out  1  NMI handler active.
- epc  out  32  saved return PC, maskable.
- nmi_epc  out  32  saved return PC, NMI.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; state IDLE; nmi_pending=0; NMI edge-detect register=0.
- NMI detect: nmi is registered each cycle.
  - nmi=1 with previous sample 0 sets nmi_pending.
  - nmi_pending clears only when the NMI is taken.
  - nmi_pending is held while en_nmi=0 and is taken once en_nmi rises.
- States:
  - IDLE: no handler active.
  - ISR: in_isr=1.
  - NMI: in_nmi=1, entered from IDLE.
  - NMI_ISR: in_isr=1 and in_nmi=1, NMI preempted an ISR.
- Evaluation happens only in a cycle with instr_retire=1. Priority order:
  1. mret.
  2. NMI take.
  3. Maskable take.
- mret handling:
  - In NMI: go to IDLE, redirect_pc=nmi_epc.
  - In NMI_ISR: go to ISR, redirect_pc=nmi_epc.
  - In ISR: go to IDLE, redirect_pc=epc.
  - In IDLE: ignored; no redirect.
  - No take is evaluated in the same cycle as an accepted mret. Pending requests are taken at the next retire.
- NMI take:
  - Condition: nmi_pending=1, en_nmi=1, state IDLE or ISR.
  - Action: nmi_epc<=pc_next, redirect_pc=NMI_VEC, state to NMI or NMI_ISR.
  - No nesting inside an NMI; nmi_pending stays set until return.
- Maskable take:
  - Condition: int_req=1, en_inter=1, state IDLE.
  - Action: epc<=pc_next, redirect_pc=VEC_BASE+int_num*VEC_STRIDE (32-bit, wraps modulo 2^32).
  - Also asserts int_ack with ack_num=int_num sampled that cycle; state to ISR.
  - No maskable nesting.
- Latency:
  - redirect, int_ack and the state/epc updates are all registered.
  - All appear the cycle after the deciding retire.
  - redirect and int_ack are high for exactly one cycle.
  - in_isr and in_nmi change in that same cycle.
- If int_req drops before a retire, nothing is taken and no ack is issued.
- en_inter=0 while in ISR has no effect on the active handler.
- Reset asserted mid-handler aborts everything, including any redirect in flight.

Test Plan:
- Reset, then int_req=1, int_num=3, en_inter=1, retire with pc_next=0x200.
  - Next cycle: redirect=1, redirect_pc=0x4C, int_ack=1, ack_num=3, epc=0x200, in_isr=1.
  - Following cycle: redirect=0, int_ack=0.
- In ISR, retire with mret=1 -> redirect_pc=0x200, in_isr=0. int_req still 1 -> taken again at the next retire, not in the mret cycle.
- In ISR with pc_next=0x50, pulse nmi (en_nmi=1), retire -> redirect_pc=0x20, nmi_epc=0x50, in_isr=1, in_nmi=1.
  - mret -> back to 0x50, ISR state.
  - mret -> epc target, IDLE.
- nmi rise and int_req=1 (int_num=5) at the same retire from IDLE -> NMI taken, no int_ack. After mret, int 5 is taken with redirect_pc=0x54.
- nmi held high for 10 cycles with en_nmi=0, then en_nmi=1 and retire -> exactly one NMI take. nmi still high after mret -> no second take.
- rst=0 asserted in the cycle after a take decision -> redirect, int_ack, in_isr and epc all read 0 immediately. mret while IDLE -> no redirect.
